// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, ALU opcodes and source-select encodings.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 8;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;

    // Register input source (a_sel / b_sel)
    localparam logic SRC_MEM = 1'b0;
    localparam logic SRC_ALU = 1'b1;

    // Operand / store / jump-base source (A or B)
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cpu_datapath_if.sv
// ============================================================================
// Module      : cpu_datapath_if
// Description : External single-port memory bus between datapath and memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cpu_datapath_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we_o,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we_o,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module      : cpu_alu
// Description : Combinational ALU: ADD (carry dropped), AND, NOT X, else zero.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  wire logic [DATA_W-1:0] i_x,
    input  wire logic [DATA_W-1:0] i_y,
    input  wire logic [2:0]        i_opcode,
    output logic      [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_opcode)
            ALU_ADD: o_result = i_x + i_y;
            ALU_AND: o_result = i_x & i_y;
            ALU_NOT: o_result = ~i_x;
            default: o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_datapath.sv
// ============================================================================
// Module      : cpu_datapath
// Description : PC, IR, A, B, ALU output register and zero flag of the 8-bit CPU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              pc_we,
    input  wire logic              pc_sel,
    input  wire logic              pc_jmp_sel,
    input  wire logic [3:0]        pc_offset,
    input  wire logic              addr_sel,
    input  wire logic [3:0]        addr_offset,
    input  wire logic              mem_sel,
    input  wire logic              mem_we,
    input  wire logic [2:0]        alu_opcode,
    input  wire logic              alu_sel_a,
    input  wire logic              alu_sel_b,
    input  wire logic              alu_we,
    input  wire logic              zf_we,
    input  wire logic              ir_we,
    input  wire logic              a_sel,
    input  wire logic              b_sel,
    input  wire logic              a_we,
    input  wire logic              b_we,
    input  wire logic              halt,
    cpu_datapath_if.master         mem,
    output logic      [7:0]        instr,
    output logic                   zf,
    output logic      [ADDR_W-1:0] pc,
    output logic      [DATA_W-1:0] reg_a,
    output logic      [DATA_W-1:0] reg_b
);

    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic              r_zf;

    logic [DATA_W-1:0] w_jmp_base;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] w_alu_res;

    assign w_jmp_base = (pc_jmp_sel == SEL_B) ? r_b : r_a;
    assign w_pc_next  = pc_sel ? (ADDR_W'(w_jmp_base) + ADDR_W'(pc_offset))
                               : (r_pc + ADDR_W'(1));

    assign w_x = (alu_sel_a == SEL_B) ? r_b : r_a;
    assign w_y = (alu_sel_b == SEL_B) ? r_b : r_a;

    cpu_alu #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .i_x      (w_x),
        .i_y      (w_y),
        .i_opcode (alu_opcode),
        .o_result (w_alu_res)
    );

    assign mem.mem_addr  = addr_sel ? (r_pc + ADDR_W'(addr_offset)) : r_pc;
    assign mem.mem_wdata = (mem_sel == SEL_B) ? r_b : r_a;
    assign mem.mem_we_o  = mem_we & ~halt;

    // Zero flag samples the live ALU result, not the ALU output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_zf  <= 1'b0;
        end else if (!halt) begin
            if (pc_we)  r_pc  <= w_pc_next;
            if (ir_we)  r_ir  <= mem.mem_rdata[7:0];
            if (alu_we) r_alu <= w_alu_res;
            if (zf_we)  r_zf  <= (w_alu_res == '0);
            if (a_we)   r_a   <= (a_sel == SRC_ALU) ? r_alu : mem.mem_rdata;
            if (b_we)   r_b   <= (b_sel == SRC_ALU) ? r_alu : mem.mem_rdata;
        end
    end

    assign pc    = r_pc;
    assign instr = r_ir;
    assign zf    = r_zf;
    assign reg_a = r_a;
    assign reg_b = r_b;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Self-checking bench for cpu_datapath against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pc_we, pc_sel, pc_jmp_sel, addr_sel, mem_sel, mem_we;
    logic [3:0] pc_offset, addr_offset;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
    logic       a_sel, b_sel, a_we, b_we, halt;
    logic [7:0] instr, pc, reg_a, reg_b;
    logic       zf;

    int checks = 0;
    int failures = 0;

    // Architectural model state
    logic [7:0] m_pc, m_ir, m_a, m_b, m_alu;
    logic       m_zf;

    cpu_datapath_if u_if ();

    cpu_datapath u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .pc_jmp_sel  (pc_jmp_sel),
        .pc_offset   (pc_offset),
        .addr_sel    (addr_sel),
        .addr_offset (addr_offset),
        .mem_sel     (mem_sel),
        .mem_we      (mem_we),
        .alu_opcode  (alu_opcode),
        .alu_sel_a   (alu_sel_a),
        .alu_sel_b   (alu_sel_b),
        .alu_we      (alu_we),
        .zf_we       (zf_we),
        .ir_we       (ir_we),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .a_we        (a_we),
        .b_we        (b_we),
        .halt        (halt),
        .mem         (u_if.master),
        .instr       (instr),
        .zf          (zf),
        .pc          (pc),
        .reg_a       (reg_a),
        .reg_b       (reg_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd0:    return x + y;
            3'd1:    return x & y;
            3'd2:    return ~x;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clr_ctrl();
        pc_we = 0; pc_sel = 0; pc_jmp_sel = 0; pc_offset = 0;
        addr_sel = 0; addr_offset = 0; mem_sel = 0; mem_we = 0;
        alu_opcode = 0; alu_sel_a = 0; alu_sel_b = 0; alu_we = 0; zf_we = 0; ir_we = 0;
        a_sel = 0; b_sel = 0; a_we = 0; b_we = 0; halt = 0;
        u_if.mem_rdata = 8'h00;
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0; m_zf = 0;
    endtask

    // Advance one rising edge, evolving the model from the pre-edge state.
    task automatic step();
        logic [7:0] res, n_pc, n_ir, n_a, n_b, n_alu;
        logic       n_zf;
        n_pc = m_pc; n_ir = m_ir; n_a = m_a; n_b = m_b; n_alu = m_alu; n_zf = m_zf;
        res = alu_ref(alu_opcode, alu_sel_a ? m_b : m_a, alu_sel_b ? m_b : m_a);
        if (!halt) begin
            if (pc_we)  n_pc = pc_sel ? ((pc_jmp_sel ? m_b : m_a) + {4'h0, pc_offset}) : m_pc + 8'd1;
            if (ir_we)  n_ir = u_if.mem_rdata;
            if (alu_we) n_alu = res;
            if (zf_we)  n_zf = (res == 8'h00);
            if (a_we)   n_a = a_sel ? m_alu : u_if.mem_rdata;
            if (b_we)   n_b = b_sel ? m_alu : u_if.mem_rdata;
        end
        @(posedge clk);
        m_pc = n_pc; m_ir = n_ir; m_a = n_a; m_b = n_b; m_alu = n_alu; m_zf = n_zf;
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        clr_ctrl(); u_if.mem_rdata = v; a_we = 1; step(); clr_ctrl();
    endtask

    task automatic load_b(input logic [7:0] v);
        clr_ctrl(); u_if.mem_rdata = v; b_we = 1; step(); clr_ctrl();
    endtask

    task automatic set_pc(input logic [7:0] v);
        load_b(v); pc_we = 1; pc_sel = 1; pc_jmp_sel = 1; step(); clr_ctrl();
    endtask

    task automatic test_reset();
        clr_ctrl(); model_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({pc, instr, zf} !== 17'h0) begin failures++; $display("FAIL reset_pc_ir_zf got %h/%h/%b want 0", pc, instr, zf); end
        checks++; if ({reg_a, reg_b} !== 16'h0) begin failures++; $display("FAIL reset_ab got %h/%h want 0", reg_a, reg_b); end
        checks++; if ({u_if.mem_addr, u_if.mem_wdata} !== 16'h0) begin failures++; $display("FAIL reset_mem got %h/%h want 0", u_if.mem_addr, u_if.mem_wdata); end
        mem_we = 1; #1;
        checks++; if (u_if.mem_we_o !== 1'b1) begin failures++; $display("FAIL reset_we_o got %b want 1", u_if.mem_we_o); end
        clr_ctrl();
        reset_n = 1;
    endtask

    task automatic test_fetch();
        clr_ctrl(); ir_we = 1; pc_we = 1; u_if.mem_rdata = 8'h6A; step(); clr_ctrl();
        checks++; if (instr !== 8'h6A || m_ir !== 8'h6A) begin failures++; $display("FAIL fetch_ir got %h want 6a", instr); end
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL fetch_pc got %h want 01", pc); end
    endtask

    task automatic test_alu_to_reg();
        load_a(8'hF0); load_b(8'h10);
        alu_opcode = 3'b000; alu_sel_b = 1; alu_we = 1; zf_we = 1; step(); clr_ctrl();
        checks++; if (zf !== 1'b1) begin failures++; $display("FAIL add_wrap_zf got %b want 1", zf); end
        a_sel = 1; a_we = 1; step(); clr_ctrl();
        checks++; if (reg_a !== 8'h00) begin failures++; $display("FAIL alu_to_a got %h want 00", reg_a); end
    endtask

    task automatic test_alu_ops();
        load_a(8'hFF); load_b(8'h5A);
        alu_opcode = 3'b010; alu_we = 1; zf_we = 1; step(); clr_ctrl();
        checks++; if (zf !== 1'b1) begin failures++; $display("FAIL not_zf got %b want 1", zf); end
        load_a(8'h0F); load_b(8'hF0);
        alu_opcode = 3'b001; alu_sel_b = 1; alu_we = 1; zf_we = 1; step(); clr_ctrl();
        checks++; if (zf !== 1'b1) begin failures++; $display("FAIL and_zf got %b want 1", zf); end
        load_a(8'h01); load_b(8'h01);
        alu_opcode = 3'b000; alu_sel_b = 1; alu_we = 1; zf_we = 1; step(); clr_ctrl();
        checks++; if (zf !== 1'b0) begin failures++; $display("FAIL add_zf got %b want 0", zf); end
        b_sel = 1; b_we = 1; step(); clr_ctrl();
        checks++; if (reg_b !== 8'h02) begin failures++; $display("FAIL add_result got %h want 02", reg_b); end
    endtask

    task automatic test_pc_wrap();
        set_pc(8'hFE);
        addr_sel = 1; addr_offset = 4'h5; #1;
        checks++; if (u_if.mem_addr !== 8'h03) begin failures++; $display("FAIL addr_wrap got %h want 03", u_if.mem_addr); end
        clr_ctrl();
        load_b(8'hFC);
        pc_we = 1; pc_sel = 1; pc_jmp_sel = 1; pc_offset = 4'h6; step(); clr_ctrl();
        checks++; if (pc !== 8'h02) begin failures++; $display("FAIL jump_wrap got %h want 02", pc); end
        set_pc(8'hFF);
        pc_we = 1; step(); clr_ctrl();
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL inc_wrap got %h want 00", pc); end
    endtask

    task automatic test_halt();
        logic [7:0] s_pc, s_ir, s_a, s_b;
        logic       s_zf;
        load_a(8'h33); load_b(8'h44);
        s_pc = pc; s_ir = instr; s_a = reg_a; s_b = reg_b; s_zf = zf;
        halt = 1; pc_we = 1; ir_we = 1; alu_we = 1; zf_we = 1; a_we = 1; b_we = 1;
        mem_we = 1; u_if.mem_rdata = 8'hC3; alu_opcode = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (u_if.mem_we_o !== 1'b0) begin failures++; $display("FAIL halt_we_o got %b want 0", u_if.mem_we_o); end
            step();
            checks++; if ({pc, instr, reg_a, reg_b, zf} !== {s_pc, s_ir, s_a, s_b, s_zf}) begin
                failures++; $display("FAIL halt_hold got %h %h %h %h %b want %h %h %h %h %b",
                    pc, instr, reg_a, reg_b, zf, s_pc, s_ir, s_a, s_b, s_zf);
            end
        end
        halt = 0; step(); clr_ctrl();
        checks++; if ({pc, instr, reg_a, reg_b, zf} !== {m_pc, m_ir, m_a, m_b, m_zf} || pc !== s_pc + 8'd1) begin
            failures++; $display("FAIL halt_resume got %h %h %h %h %b want %h %h %h %h %b",
                pc, instr, reg_a, reg_b, zf, m_pc, m_ir, m_a, m_b, m_zf);
        end
    endtask

    task automatic test_async_reset();
        set_pc(8'h20); load_a(8'h55);
        checks++; if (reg_a !== 8'h55 || pc !== 8'h20) begin failures++; $display("FAIL pre_reset got a=%h pc=%h want 55/20", reg_a, pc); end
        #2; reset_n = 0; #1;
        checks++; if (reg_a !== 8'h00 || pc !== 8'h00 || reg_b !== 8'h00) begin
            failures++; $display("FAIL async_reset got a=%h pc=%h b=%h want 0", reg_a, pc, reg_b);
        end
        model_reset();
        @(negedge clk); reset_n = 1;
        pc_we = 1; step(); clr_ctrl();
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL post_reset_pc got %h want 01", pc); end
    endtask

    task automatic test_random();
        logic [7:0] e_addr, e_wdata;
        for (int i = 0; i < 400; i++) begin
            {pc_we, pc_sel, pc_jmp_sel, addr_sel, mem_sel, mem_we} = 6'($urandom);
            {alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we, a_sel, b_sel, a_we, b_we} = 9'($urandom);
            pc_offset = 4'($urandom); addr_offset = 4'($urandom);
            alu_opcode = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            halt = ($urandom_range(0, 7) == 0);
            u_if.mem_rdata = 8'($urandom);
            #1;
            e_addr = addr_sel ? m_pc + {4'h0, addr_offset} : m_pc;
            e_wdata = mem_sel ? m_b : m_a;
            checks++; if ({u_if.mem_addr, u_if.mem_wdata, u_if.mem_we_o} !== {e_addr, e_wdata, mem_we & ~halt}) begin
                failures++; $display("FAIL rand_comb[%0d] got %h %h %b want %h %h %b", i,
                    u_if.mem_addr, u_if.mem_wdata, u_if.mem_we_o, e_addr, e_wdata, mem_we & ~halt);
            end
            step();
            checks++; if ({pc, instr, reg_a, reg_b, zf} !== {m_pc, m_ir, m_a, m_b, m_zf}) begin
                failures++; $display("FAIL rand_state[%0d] got %h %h %h %h %b want %h %h %h %h %b", i,
                    pc, instr, reg_a, reg_b, zf, m_pc, m_ir, m_a, m_b, m_zf);
            end
        end
        clr_ctrl();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alu_to_reg();
        test_alu_ops();
        test_pc_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/cpu_datapath.md
# cpu_datapath

Register-and-ALU datapath of the 8-bit CPU; consumes every strobe and select produced by the control unit and returns the instruction and zero flag to it. Holds the PC, instruction register (IR), registers A and B, the ALU output register and the zero flag. Drives the external single-port memory: address, write data and write enable.

## Interface
- `DATA_W`, 8, data/register width
- `ADDR_W`, 8, PC and memory address width (256-byte space)

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `pc_we`, `pc_sel`, `pc_jmp_sel` in 1 each: PC write enable; next-PC select (0 = PC+1, 1 = jump); jump base select (0 = A, 1 = B)
- `pc_offset` in 4: jump offset, zero-extended
- `addr_sel` in 1: memory address select (0 = PC, 1 = PC+`addr_offset`)
- `addr_offset` in 4: load/store offset, zero-extended
- `mem_sel` in 1: store data source (0 = A, 1 = B)
- `mem_we` in 1: memory write request
- `alu_opcode` in 3: ALU operation
- `alu_sel_a`, `alu_sel_b` in 1 each: ALU operand source (0 = A, 1 = B)
- `alu_we`, `zf_we`, `ir_we` in 1 each: ALU output register, zero flag, IR write enables
- `a_sel`, `b_sel` in 1 each: register input source (0 = `mem_rdata`, 1 = ALU output register)
- `a_we`, `b_we` in 1 each: register A/B write enables
- `halt` in 1: freeze; blocks every state update
- `mem_rdata` in DATA_W: memory read data (synchronous-read memory, valid the cycle after the address)
- `mem_addr` out ADDR_W: memory address, combinational
- `mem_wdata` out DATA_W: store data, combinational
- `mem_we_o` out 1: `mem_we & ~halt`
- `instr` out 8: IR contents
- `zf` out 1: zero flag register
- `pc` out ADDR_W, `reg_a` out DATA_W, `reg_b` out DATA_W: architectural state, for observation

## Operation
- Reset (`reset_n` low, asynchronous): PC, IR, A, B, ALU output register and ZF all clear to 0. Outputs therefore read `pc`=0, `instr`=0, `zf`=0, `reg_a`/`reg_b`=0, `mem_addr`=0, `mem_wdata`=0. `mem_we_o` follows `mem_we & ~halt` and is not reset.
- PC write (`pc_we`):
  - `pc_sel`=0: PC ← PC+1.
  - `pc_sel`=1: PC ← (`pc_jmp_sel` ? B : A) + `pc_offset`.
  - Both wrap mod 2^ADDR_W; 0xFF+1 gives 0x00.
- `mem_addr` = `addr_sel` ? PC+`addr_offset` : PC, wrapping mod 2^ADDR_W.
- `mem_wdata` = `mem_sel` ? B : A.
- ALU (combinational). Operands: X = `alu_sel_a` ? B : A, Y = `alu_sel_b` ? B : A.
  - 000: X+Y, carry discarded.
  - 001: X&Y.
  - 010: ~X.
  - All other codes: 0x00.
- `alu_we`: ALU output register ← ALU result. `zf_we`: ZF ← (ALU result == 0), taken from the combinational result in the same cycle, not from the ALU output register.
- `ir_we`: IR ← `mem_rdata`.
- `a_we`/`b_we`: the register ← `mem_rdata` or the ALU output register, per `a_sel`/`b_sel`. Both may write in the same cycle.
- `halt`=1 suppresses every register update and forces `mem_we_o`=0. Combinational outputs keep tracking the held state.

## Timing
- Every register write takes effect at the rising edge where its enable is high. The new value is visible on the outputs in the following cycle.
- ALU result to register A/B takes two edges: `alu_we` at edge n, `a_we`/`b_we` with select=1 at edge n+1 or later.
- A write to a register used as an ALU operand in the same cycle uses the old value for the ALU.
- `pc_we` concurrent with A/B write: the jump uses the pre-edge A/B value.
- Reset asserted mid-instruction clears all state immediately, with no clock required. The first rising edge after deassertion performs normal updates.

## Structure
- Shared package `cpu_pkg`: `DATA_W`/`ADDR_W` defaults, ALU opcode constants (ADD, AND, NOT), register/memory source select encodings.
- One combinational sub-module, `cpu_alu`: operands X, Y and opcode in; result out. The zero compare stays in `cpu_datapath`.

## Test plan
- Reset, then `ir_we`=1, `pc_we`=1, `pc_sel`=0, `mem_rdata`=0x6A for one edge -> `instr`=0x6A, `pc`=0x01.
- Load A=0xF0, B=0x10 via `mem_rdata`; `alu_opcode`=000, sel_a=0, sel_b=1, `alu_we`, `zf_we` -> ALU output register 0x00, `zf`=1. Then `a_sel`=1, `a_we` -> `reg_a`=0x00.
- NOT with A=0xFF and `zf_we` -> ZF=1. AND with A=0x0F, B=0xF0 -> result 0x00, ZF=1. ADD with A=0x01, B=0x01 -> result 0x02, ZF=0.
- PC wrap and offsets:
  - PC=0xFE, `addr_sel`=1, `addr_offset`=0x5 -> `mem_addr`=0x03.
  - B=0xFC, `pc_sel`=1, `pc_jmp_sel`=1, `pc_offset`=0x6, `pc_we` -> `pc`=0x02.
- `halt`=1 with all enables and `mem_we` high for 3 edges -> no state change and `mem_we_o`=0. Drop `halt` -> updates resume at the next edge.
- Assert `reset_n` low between edges while A=0x55 and PC=0x20 -> `reg_a`=0 and `pc`=0 before the next edge.
